// File: rtl/gate_truth_checker.sv
// On-chip BIST for the two-input gate bank: walks all four {a,b} vectors,
// waits a programmable settle time, and checks the eight gate outputs.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] resp,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [7:0] first_fail_bits
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] vec;
    logic [1:0] vec_inc;
    logic [3:0] settle_cnt;
    logic [7:0] expected;
    logic [7:0] mismatch;
    logic       vec_fail;

    // Golden word ordered {xnor,xor,nor,nand,not_b,not_a,or,and}.
    function automatic logic [7:0] golden(input logic a, input logic b);
        golden = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    endfunction

    always_comb begin
        expected = golden(vec[1], vec[0]);
        mismatch = expected ^ resp;
        vec_fail = |mismatch;
        vec_inc  = vec + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy       = 1'b1;
                state_next = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt <= 4'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy       = 1'b1;
                state_next = (vec == 2'd3) ? FINISH : APPLY;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Drive registers change only on the edge entering APPLY (or leaving
    // FINISH), so the stimulus is stable for the whole vector window.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec             <= 2'd0;
            drv_a           <= 1'b0;
            drv_b           <= 1'b0;
            settle_cnt      <= 4'd0;
            pass            <= 1'b0;
            err_count       <= 3'd0;
            fail_vec        <= 4'd0;
            first_fail_bits <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec             <= 2'd0;
                        drv_a           <= 1'b0;
                        drv_b           <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 3'd0;
                        fail_vec        <= 4'd0;
                        first_fail_bits <= 8'd0;
                    end
                end
                APPLY: begin
                    settle_cnt <= 4'(SETTLE_CYCLES);
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    if (vec_fail) begin
                        fail_vec[vec] <= 1'b1;
                        err_count     <= err_count + 3'd1;
                        if (err_count == 3'd0) begin
                            first_fail_bits <= mismatch;
                        end
                    end
                    if (vec != 2'd3) begin
                        vec   <= vec_inc;
                        drv_a <= vec_inc[1];
                        drv_b <= vec_inc[0];
                    end else begin
                        // Pass must already be valid during the FINISH cycle.
                        pass <= (err_count == 3'd0) && !vec_fail;
                    end
                end
                FINISH: begin
                    vec   <= 2'd0;
                    drv_a <= 1'b0;
                    drv_b <= 1'b0;
                end
                default: begin
                    vec <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a behavioural gate bank with
// injectable faults feeds two checker builds (settle 2 and settle 0).
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    int         fault_mode = 0;
    int         sel = 0;
    int         assert_count = 0;
    int         fail_count = 0;

    logic [7:0] resp0, resp1;
    logic       drv_a0, drv_b0, busy0, done0, pass0;
    logic       drv_a1, drv_b1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fvec0, fvec1;
    logic [7:0] ffb0, ffb1;

    logic       o_drv_a, o_drv_b, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [3:0] o_fvec;
    logic [7:0] o_ffb;

    always #5 clk = ~clk;

    gate_truth_checker #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .resp(resp0),
        .drv_a(drv_a0), .drv_b(drv_b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fvec0),
        .first_fail_bits(ffb0)
    );

    gate_truth_checker #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start1), .resp(resp1),
        .drv_a(drv_a1), .drv_b(drv_b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fvec1),
        .first_fail_bits(ffb1)
    );

    // Behavioural gate bank, bit0 = and_out; mode 1 sticks and at 0, mode 2 inverts xor.
    function automatic logic [7:0] gate_model(input logic a, input logic b, input int mode);
        logic [7:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = !a;
        r[3] = !b;
        r[4] = !(a & b);
        r[5] = !(a | b);
        r[6] = a ^ b;
        r[7] = !(a ^ b);
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2) r[6] = !r[6];
        return r;
    endfunction

    always_comb begin
        resp0 = gate_model(drv_a0, drv_b0, fault_mode);
        resp1 = gate_model(drv_a1, drv_b1, fault_mode);
    end

    always_comb begin
        o_drv_a = (sel == 0) ? drv_a0 : drv_a1;
        o_drv_b = (sel == 0) ? drv_b0 : drv_b1;
        o_busy  = (sel == 0) ? busy0  : busy1;
        o_done  = (sel == 0) ? done0  : done1;
        o_pass  = (sel == 0) ? pass0  : pass1;
        o_err   = (sel == 0) ? err0   : err1;
        o_fvec  = (sel == 0) ? fvec0  : fvec1;
        o_ffb   = (sel == 0) ? ffb0   : ffb1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    // One full run; extra start pulses are raised in cycles x1/x2 (n+1 is FINISH).
    task automatic applyStimulus(input int settle, input int x1, input int x2,
                                 input logic [3:0] exp_fvec, input logic [2:0] exp_err,
                                 input logic [7:0] exp_ffb, input logic exp_pass);
        int n;
        int vi;
        n = 4 * (settle + 2);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int c = 1; c <= n; c++) begin
            vi = (c - 1) / (settle + 2);
            checkOutput("busy", 32'(o_busy), 32'd1);
            checkOutput("done_early", 32'(o_done), 32'd0);
            checkOutput("drv_a", 32'(o_drv_a), 32'((vi >> 1) & 1));
            checkOutput("drv_b", 32'(o_drv_b), 32'(vi & 1));
            if (c == 1) begin
                checkOutput("clr_err", 32'(o_err), 32'd0);
                checkOutput("clr_fvec", 32'(o_fvec), 32'd0);
                checkOutput("clr_ffb", 32'(o_ffb), 32'd0);
                checkOutput("clr_pass", 32'(o_pass), 32'd0);
            end
            if (c == x1 || c == x2) set_start(1'b1);
            tick();
            set_start(1'b0);
        end
        checkOutput("done", 32'(o_done), 32'd1);
        checkOutput("busy_fin", 32'(o_busy), 32'd0);
        checkOutput("pass", 32'(o_pass), 32'(exp_pass));
        checkOutput("err_count", 32'(o_err), 32'(exp_err));
        checkOutput("fail_vec", 32'(o_fvec), 32'(exp_fvec));
        checkOutput("first_fail", 32'(o_ffb), 32'(exp_ffb));
        if (x1 == n + 1 || x2 == n + 1) set_start(1'b1);
        tick();
        set_start(1'b0);
        checkOutput("done_clr", 32'(o_done), 32'd0);
        checkOutput("busy_idle", 32'(o_busy), 32'd0);
        checkOutput("hold_err", 32'(o_err), 32'(exp_err));
        checkOutput("hold_pass", 32'(o_pass), 32'(exp_pass));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(o_pass), 32'd0);
        checkOutput({tag, "_err"}, 32'(o_err), 32'd0);
        checkOutput({tag, "_fvec"}, 32'(o_fvec), 32'd0);
        checkOutput({tag, "_ffb"}, 32'(o_ffb), 32'd0);
        checkOutput({tag, "_drv_a"}, 32'(o_drv_a), 32'd0);
        checkOutput({tag, "_drv_b"}, 32'(o_drv_b), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        sel = 0;
        check_all_zero("rst0");
        sel = 1;
        check_all_zero("rst1");

        sel = 0;
        fault_mode = 0;
        applyStimulus(2, -1, -1, 4'b0000, 3'd0, 8'h00, 1'b1);
        fault_mode = 1;
        applyStimulus(2, -1, -1, 4'b1000, 3'd1, 8'h01, 1'b0);
        fault_mode = 2;
        applyStimulus(2, -1, -1, 4'b1111, 3'd4, 8'h40, 1'b0);
        // Back-to-back good run with ignored starts mid-run and during FINISH.
        fault_mode = 0;
        applyStimulus(2, 3, 10, 4'b0000, 3'd0, 8'h00, 1'b1);
        applyStimulus(2, 17, -1, 4'b0000, 3'd0, 8'h00, 1'b1);

        // Reset in cycle 7 of a run while vector 01 is driven.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("pre_rst_drv_b", 32'(o_drv_b), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        tick();
        checkOutput("midrst_idle", 32'(o_busy), 32'd0);
        applyStimulus(2, -1, -1, 4'b0000, 3'd0, 8'h00, 1'b1);

        sel = 1;
        applyStimulus(0, -1, -1, 4'b0000, 3'd0, 8'h00, 1'b1);
        fault_mode = 2;
        applyStimulus(0, -1, -1, 4'b1111, 3'd4, 8'h40, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Sequential self-test engine that drives the two-input gate bank (`digital_gates`) from the stimulus side and checks its responses in hardware.
- On a start pulse it steps through all four {a,b} combinations and waits a programmable settle time after each one.
- It samples the eight gate outputs, compares them with the golden truth table and accumulates a pass/fail summary.
- It sits beside `digital_gates` as an on-chip BIST and replaces the bench's exhaustive stimulus loop.

Parameters:
- SETTLE_CYCLES, 2, extra cycles a vector is held before the response is sampled (legal 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a run; accepted only when idle.
- resp  input  8  DUT outputs, ordered {xnor,xor,nor,nand,not_b,not_a,or,and} (bit0 = and_out).
- drv_a  output  1  registered stimulus to the DUT input a.
- drv_b  output  1  registered stimulus to the DUT input b.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero failing vectors.
- err_count  output  3  number of failing vectors in the last run (0..4).
- fail_vec  output  4  bit i set when vector i ({a,b}=i) mismatched.
- first_fail_bits  output  8  XOR of expected and resp for the lowest-index failing vector; 0 if none failed.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0.
  - FSM goes to IDLE and the settle counter clears.
  - Reset dominates start and any in-flight run; partial results are discarded.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, FINISH.
- IDLE:
  - drv_a/drv_b = 0.
  - start=1 moves to APPLY and clears pass, err_count, fail_vec and first_fail_bits.
- APPLY:
  - The vector index v (2 bits) is loaded: 0 on entry from IDLE, otherwise v+1.
  - drv_a = v[1] and drv_b = v[0] become valid this cycle.
  - The settle counter loads SETTLE_CYCLES.
  - Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: the counter decrements once per cycle; the FSM moves to SAMPLE when the counter reaches 1.
- SAMPLE:
  - The FSM compares resp with the expected word for v: and=a&b, or=a|b, not_a=~a, not_b=~b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - On mismatch: fail_vec[v] is set and err_count increments. If this is the first failure of the run, the mismatch word is captured into first_fail_bits.
  - Next state is APPLY if v<3, else FINISH.
- Timing: each vector occupies exactly SETTLE_CYCLES+2 cycles, and drv_a/drv_b stay stable across those cycles. busy is high from the cycle after start through the last SAMPLE cycle.
- FINISH:
  - Lasts one cycle: done=1, busy=0, and pass = (err_count==0 after the final update).
  - Returns to IDLE.
  - Results hold until the next accepted start or reset.
- start is ignored while busy=1 and during FINISH. start in the first IDLE cycle after FINISH is accepted.
- Run latency: done asserts 4*(SETTLE_CYCLES+2)+1 cycles after the cycle in which start was sampled.
- err_count saturates naturally at 4 and never wraps. v wraps only through FINISH, never directly back to 0.
- resp is treated as asynchronous to drive changes; it is only sampled in SAMPLE.

Test Plan:
- Correct model, SETTLE_CYCLES=2, one start pulse:
  - busy high for 16 cycles; drv_{a,b} sequence 00, 01, 10, 11, each held 4 cycles.
  - done pulses at start+17; pass=1, err_count=0, fail_vec=0000, first_fail_bits=00.
- and_out stuck-at-0 → fail_vec=1000, err_count=1, first_fail_bits=8'h01, pass=0.
- xor_out inverted → fail_vec=1111, err_count=4, first_fail_bits=8'h40, pass=0.
- Extra start pulses at cycles 3 and 10 of a run → ignored; the run completes with unchanged timing. A start in the cycle after done starts a new run, and results clear at acceptance.
- rst asserted in cycle 7 of a run → next cycle all outputs 0 and FSM in IDLE. A fresh start then gives a clean pass.
- SETTLE_CYCLES=0 build, correct model → each vector held 2 cycles, done at start+9, pass=1.
